// File: rtl/hex_digit_scanner_if.sv
// Purpose : load handshake and scan outputs of the hex digit scanner.
// Ports   : load_valid/load_value/load_ready form the load handshake;
//           hex_number/digit_enable/digit_blank/frame_done drive the display.
// The scanner uses the slave modport; the producer/display side uses master.
interface hex_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic                      load_ready;
    logic [3:0]                hex_number;
    logic [NUM_DIGITS-1:0]     digit_enable;
    logic                      digit_blank;
    logic                      frame_done;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready,
        input  hex_number,
        input  digit_enable,
        input  digit_blank,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready,
        output hex_number,
        output digit_enable,
        output digit_blank,
        output frame_done
    );
endinterface

// File: rtl/hex_digit_scanner.sv
// Purpose     : time-multiplexed N-digit hex scanner feeding one 7-segment decoder.
// Latency     : a load shows from the next frame boundary (worst case rest of frame + one frame).
// Backpressure: load_ready low while a value waits in pending; it frees at the committing boundary.
//
// Ports: clk, reset (async, active-high), bus (hex_digit_scanner_if.slave):
//   load_valid/load_value/load_ready - value handshake, nibble 0 is rightmost digit
//   hex_number/digit_enable          - registered nibble and one-hot digit select
//   digit_blank                      - registered "segments off" request for this digit
//   frame_done                       - one-cycle pulse after each frame wrap
// Option: define HEX_SCANNER_LEADING_ZERO_BLANK_EN to blank leading zero digits.
// The interface's NUM_DIGITS must equal this module's NUM_DIGITS.
module hex_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_digit_scanner_if.slave      bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      active;
    logic [VAL_W-1:0]      pending;
    logic                  pending_full;

    logic [3:0]            hex_q;
    logic [NUM_DIGITS-1:0] enable_q;
    logic                  blank_q;
    logic                  frame_done_q;

    logic                  digit_adv;
    logic                  frame_edge;
    logic                  accept;
    logic [IDX_W-1:0]      idx_nxt;
    logic [VAL_W-1:0]      active_nxt;
    logic                  blank_nxt;

    assign digit_adv  = (div_cnt == DIV_LAST);
    assign frame_edge = digit_adv && (idx == IDX_LAST);
    // Ready comes straight from the flag register, so there is no path from load_valid.
    assign accept     = bus.load_valid && !pending_full;

    // Display outputs are registered from the post-edge digit and value so they
    // all switch together on the edge where the digit advances.
    always_comb begin
        idx_nxt = idx;
        if (digit_adv) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        active_nxt = active;
        if (frame_edge && pending_full) begin
            active_nxt = pending;
        end
    end

`ifdef HEX_SCANNER_LEADING_ZERO_BLANK_EN
    // Blank digit i (i >= 1) when it and every more significant nibble are zero.
    always_comb begin
        blank_nxt = (idx_nxt != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_nxt) && (active_nxt[4*i +: 4] != 4'h0)) begin
                blank_nxt = 1'b0;
            end
        end
    end
`else
    always_comb begin
        blank_nxt = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            idx          <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            hex_q        <= 4'h0;
            enable_q     <= NUM_DIGITS'(1);
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt <= digit_adv ? '0 : div_cnt + DIV_W'(1);
            idx     <= idx_nxt;
            active  <= active_nxt;

            // Accept needs pending empty, so it can never coincide with a commit.
            if (accept) begin
                pending      <= bus.load_value;
                pending_full <= 1'b1;
            end else if (frame_edge) begin
                pending_full <= 1'b0;
            end

            hex_q        <= active_nxt[{idx_nxt, 2'b00} +: 4];
            enable_q     <= NUM_DIGITS'(1) << idx_nxt;
            blank_q      <= blank_nxt;
            frame_done_q <= frame_edge;
        end
    end

    assign bus.load_ready   = !pending_full;
    assign bus.hex_number   = hex_q;
    assign bus.digit_enable = enable_q;
    assign bus.digit_blank  = blank_q;
    assign bus.frame_done   = frame_done_q;

endmodule

// File: doc/hex_digit_scanner.md
# hex_digit_scanner

Time-multiplexed digit scanner that sits directly upstream of the hex-to-seven-segment decoder. It accepts a multi-digit hexadecimal value over a valid/ready handshake and holds it in a pending register. It commits that value atomically at a frame boundary, then presents one nibble at a time on `hex_number` with a one-hot digit enable. The single downstream decoder plus external digit drivers light an N-digit common display.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 2..8.
- `SCAN_DIV`, default 50000: clock cycles each digit is held; legal range ≥ 2.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  `load_value` is presented.
- `load_value`  in  4*NUM_DIGITS  value to display; nibble 0 (bits 3:0) is the rightmost digit.
- `load_ready`  out  1  pending register empty; a load is accepted on `load_valid && load_ready`.
- `hex_number`  out  4  nibble of the active value for the current digit; feeds the decoder.
- `digit_enable`  out  NUM_DIGITS  one-hot; bit i high while digit i is scanned.
- `digit_blank`  out  1  consumer forces segments off (7'b1111111) for the current digit.
- `frame_done`  out  1  one-cycle pulse after each frame wrap.

## Operation
- State:
  - prescaler `div_cnt` counts 0..SCAN_DIV-1.
  - digit index `idx` counts 0..NUM_DIGITS-1.
  - `active` register, 4*NUM_DIGITS bits.
  - `pending` register plus `pending_full` flag.
- Prescaler behaviour:
  - Increments every cycle.
  - At SCAN_DIV-1 it wraps to 0, and `idx` advances by 1.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the edge where `div_cnt`==SCAN_DIV-1 and `idx`==NUM_DIGITS-1.
  - If `pending_full`: `active`<=`pending` and `pending_full`<=0.
  - Otherwise `active` is unchanged.
- Load handshake:
  - `load_ready` = !`pending_full`, driven from a register with no combinational path from `load_valid`.
  - On accept: `pending`<=`load_value` and `pending_full`<=1.
  - A new value never reaches `active` mid-frame.
- Simultaneous accept and frame boundary with `pending_full`=0: the load lands in `pending`, and commits at the next boundary.
- Because `load_ready`=0 while `pending_full`=1, accept and commit cannot collide on the same register.
- `load_valid` without `load_ready`: ignored, no state change; the producer must hold the value.
- Outputs `hex_number`, `digit_enable` and `digit_blank` are registered.
  - They are computed from the next `idx` and the next `active` value.
  - At every digit-advance edge they change together and reflect the new digit and the newly committed value.
- `frame_done`: registered; high for exactly the one cycle following each frame-boundary edge.

## Timing
- Reset values:
  - `div_cnt`=0, `idx`=0, `active`=0, `pending`=0, `pending_full`=0.
  - `load_ready`=1, `hex_number`=4'h0, `digit_enable`=1 (bit 0 set), `digit_blank`=0, `frame_done`=0.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously). A pending, uncommitted value is discarded.
- Each digit is held exactly SCAN_DIV cycles; one frame is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency:
  - Minimum 1 cycle: accept on the boundary cycle... not possible, since the value lands in `pending`.
  - Worst case: the remaining cycles of the current frame plus one full frame.
- `load_ready` falls the cycle after an accept, and rises the cycle after the committing boundary.

## Configuration
- Macro: `HEX_SCANNER_LEADING_ZERO_BLANK_EN`.
- Defined: `digit_blank`=1 for digit i≥1 when nibbles i..NUM_DIGITS-1 of `active` are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: `digit_blank` is tied to 0 and all digits always display.

## Test plan
- Reset behaviour: assert `reset` mid-scan with `pending_full`=1 -> all outputs at their reset values in the same cycle; `load_ready`=1; the pending value is never displayed.
- Scan order: NUM_DIGITS=4, SCAN_DIV=4; load 16'h1A2F at idle -> after the next boundary, `hex_number` is F,2,A,1, each held 4 cycles. `digit_enable` is 0001, 0010, 0100, 1000. `frame_done` pulses once every 16 cycles.
- Back-pressure: load 16'h1111, then hold `load_valid` with 16'h2222 -> `load_ready`=0 until the boundary commits 1111. 2222 is then accepted and shown one frame later; 2222 never appears mid-frame.
- Simultaneous accept at the boundary: load 16'hBEEF on the exact boundary cycle with `pending` empty -> the old value remains for the next frame, and BEEF appears the frame after.
- Blanking (macro defined): load 16'h0050 -> digits 3 and 2 have `digit_blank`=1, digits 1 and 0 show 5 and 0. Load 16'h0000 -> only digit 0 is unblanked. With the macro undefined, `digit_blank` stays 0 throughout.
